mips_control_pc_sequencer: RTL
==============================

// Module: mips_control_pc_sequencer
// PURPOSE
//  Parametrised PC sequencer: owns the fetch PC register and resolves decode-stage control flow.
//  Decode supplies an action (Inc/Jump/JumpR/Branch), a condition (None/EQ/NE/LT/LE/GT/GE) and operands.
//  The block computes the target and the taken decision, and redirects fetch with or without an
//  architectural delay slot. It also produces flush, link and fault indications for the pipeline.
// PARAMETERS
//  WIDTH         32            address/data width; must be >= 28 (jump region = pc[WIDTH-1:28])
//  RESET_VECTOR  32'h00400000  PC value loaded on reset (truncated to WIDTH)
//  DELAY_SLOT    1             1: redirect after the delay-slot fetch; 0: immediate redirect + flush
// PORTS
//  clock          in   1      single clock; all state updates on rising edge
//  reset          in   1      synchronous, active-high
//  stall          in   1      pipeline stall; blocks decode accept and PC advance
//  fetch_ready    in   1      I-mem accepts the fetch at pc this cycle
//  valid_i        in   1      decode holds a valid instruction
//  action         in   2      0 Inc, 1 Jump, 2 JumpR, 3 Branch
//  condition      in   3      0 None, 1 EQ, 2 NE, 3 LT, 4 LE, 5 GT, 6 GE
//  pc_decode      in   WIDTH  PC of the decode instruction
//  rs_value       in   WIDTH  forwarded rs
//  rt_value       in   WIDTH  forwarded rt
//  imm16          in   16     branch offset (words)
//  target26       in   26     jump index
//  pc             out  WIDTH  current fetch address
//  fetch_valid    out  1      fetch request valid
//  flush          out  1      squash the instruction entering decode (DELAY_SLOT=0 only)
//  taken          out  1      registered pulse: last accepted control op redirected
//  link_addr      out  WIDTH  pc_decode + (DELAY_SLOT ? 8 : 4), combinational
//  redirect_pend  out  1      target latched, waiting for the delay-slot fetch
//  misalign_fault out  1      registered pulse: JumpR target[1:0] != 0
//  slot_violation out  1      registered pulse: redirect accepted while redirect_pend
// BEHAVIOUR
//  Reset values: pc=RESET_VECTOR; fetch_valid=0, flush=0, taken=0, redirect_pend=0, faults=0; state RUN.
//  fetch_valid is 1 from the first cycle after reset deassertion.
//  fire   = fetch_valid & fetch_ready & !stall  -> pc <= next_pc. Otherwise pc holds.
//  accept = valid_i & !stall.
//  go     = accept & (action==Jump | action==JumpR | (action==Branch & cond_true)).
//  cond_true: EQ rs==rt; NE rs!=rt; LT/LE/GT/GE compare signed rs against 0; None -> 0.
//  action==Inc never redirects; condition is ignored for Jump/JumpR.
//  Targets (mod 2^WIDTH):
//   - Branch: pc_decode+4+(sext(imm16)<<2)
//   - Jump:   {(pc_decode+4)[WIDTH-1:28], target26, 2'b00}
//   - JumpR:  rs_value & ~3
//  misalign_fault pulses the cycle after accept of a JumpR with rs_value[1:0] != 0; the redirect still occurs.
//  taken pulses the cycle after go.
//  DELAY_SLOT=0: go at cycle t -> pc=target at t+1, regardless of fire.
//   flush=1 for exactly cycle t+1. State stays RUN.
//  DELAY_SLOT=1, state RUN:
//   - go & fire at t: the slot fetch completes; pc=target at t+1.
//   - go & !fire: latch target; -> WAIT_SLOT; redirect_pend=1 from t+1.
//  DELAY_SLOT=1, state WAIT_SLOT:
//   - next fire: pc <= latched target (not pc+4); -> RUN.
//   - go in WAIT_SLOT: ignored; slot_violation pulses next cycle; latched target unchanged.
//   - If fire and the decode accept of an illegal go coincide, the latched target wins.
//  flush is never asserted when DELAY_SLOT=1.
//  next_pc when not redirecting: pc+4, wrapping at 2^WIDTH.
//  reset at any time, including mid-WAIT_SLOT: latched target discarded; all reset values next cycle.
// TESTING
//  T1 reset, RESET_VECTOR=0x00400000, fetch_ready=1 -> pc 0x400000,0x400004,0x400008; fetch_valid=0 in reset cycle only.
//  T2 DS=1, Branch EQ, rs=rt=5, pc_decode=0x100, imm16=0xFFFF, fire -> pc=0x100 next; taken=1; link_addr=0x108; flush=0.
//  T3 DS=1, Jump target26=0x40, fetch_ready=0 for 3 cycles -> redirect_pend=1 while waiting; pc held; pc=0x100 after fire.
//  T4 DS=0, Branch GE, rs=-1 -> no redirect/taken; then GT rs=1, imm16=2 -> pc=pc_decode+12; flush=1 one cycle.
//  T5 JumpR rs=0x2003 -> pc=0x2000; misalign_fault and taken pulse; stall=1 during go -> no accept, pc held.
//  T6 DS=1: WAIT_SLOT plus a second Jump -> slot_violation pulse, first target used. Reset mid-WAIT_SLOT -> pc=RESET_VECTOR.

Source files
------------

// File: rtl/mips_control_pc_sequencer.sv
// Fetch PC register and decode-stage control-flow resolution for a MIPS-style pipeline.
// Supports architectural delay slot (redirect after slot fetch) or immediate redirect with flush.
module mips_control_pc_sequencer #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter bit          DELAY_SLOT   = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             valid_i,
  input  logic [1:0]       action,
  input  logic [2:0]       condition,
  input  logic [WIDTH-1:0] pc_decode,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             taken,
  output logic [WIDTH-1:0] link_addr,
  output logic             redirect_pend,
  output logic             misalign_fault,
  output logic             slot_violation
);

  localparam logic ST_RUN       = 1'b0;
  localparam logic ST_WAIT_SLOT = 1'b1;

  localparam logic [1:0] ACT_INC    = 2'd0;
  localparam logic [1:0] ACT_JUMP   = 2'd1;
  localparam logic [1:0] ACT_JUMPR  = 2'd2;
  localparam logic [1:0] ACT_BRANCH = 2'd3;

  localparam logic [2:0] CND_EQ = 3'd1;
  localparam logic [2:0] CND_NE = 3'd2;
  localparam logic [2:0] CND_LT = 3'd3;
  localparam logic [2:0] CND_LE = 3'd4;
  localparam logic [2:0] CND_GT = 3'd5;
  localparam logic [2:0] CND_GE = 3'd6;

  localparam logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] STEP4     = WIDTH'(4);
  localparam logic [WIDTH-1:0] LINK_OFS  = DELAY_SLOT ? WIDTH'(8) : WIDTH'(4);
  // Jump keeps the region above bit 27; empty mask when WIDTH == 28.
  localparam logic [WIDTH-1:0] JREG_MASK = {WIDTH{1'b1}} << 28;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             state_q, state_d;
  logic             fetch_valid_q;
  logic             flush_q, flush_d;
  logic             taken_q, taken_d;
  logic             misalign_q, misalign_d;
  logic             slot_viol_q, slot_viol_d;

  logic             fire, accept, go, cond_true, rs_neg, rs_zero;
  logic [WIDTH-1:0] pc_plus4, dec_plus4, branch_tgt, jump_tgt, jumpr_tgt, target;

  always_comb begin
    fire      = fetch_valid_q & fetch_ready & ~stall;
    accept    = valid_i & ~stall;
    rs_neg    = rs_value[WIDTH-1];
    rs_zero   = (rs_value == '0);
    cond_true = 1'b0;
    case (condition)
      CND_EQ:  cond_true = (rs_value == rt_value);
      CND_NE:  cond_true = (rs_value != rt_value);
      CND_LT:  cond_true = rs_neg;
      CND_LE:  cond_true = rs_neg | rs_zero;
      CND_GT:  cond_true = ~rs_neg & ~rs_zero;
      CND_GE:  cond_true = ~rs_neg;
      default: cond_true = 1'b0;
    endcase

    pc_plus4   = pc_q + STEP4;
    dec_plus4  = pc_decode + STEP4;
    branch_tgt = dec_plus4 + ({{(WIDTH-16){imm16[15]}}, imm16} << 2);
    jump_tgt   = (dec_plus4 & JREG_MASK) | WIDTH'({target26, 2'b00});
    jumpr_tgt  = rs_value & ~WIDTH'(3);

    case (action)
      ACT_JUMP:  target = jump_tgt;
      ACT_JUMPR: target = jumpr_tgt;
      default:   target = branch_tgt;
    endcase

    go = accept & ((action == ACT_JUMP) | (action == ACT_JUMPR) |
                   ((action == ACT_BRANCH) & cond_true));
  end

  always_comb begin
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    state_d     = state_q;
    flush_d     = 1'b0;
    taken_d     = 1'b0;
    slot_viol_d = 1'b0;
    misalign_d  = accept & (action == ACT_JUMPR) & (rs_value[1:0] != 2'b00);

    if (!DELAY_SLOT) begin
      if (go) begin
        pc_d    = target;
        flush_d = 1'b1;
        taken_d = 1'b1;
      end else if (fire) begin
        pc_d = pc_plus4;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (go) begin
            taken_d = 1'b1;
            if (fire) begin
              pc_d = target;
            end else begin
              tgt_d   = target;
              state_d = ST_WAIT_SLOT;
            end
          end else if (fire) begin
            pc_d = pc_plus4;
          end
        end
        default: begin
          // A second redirect while one is pending is dropped; the latched target stays.
          slot_viol_d = go;
          if (fire) begin
            pc_d    = tgt_q;
            state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      tgt_q         <= '0;
      state_q       <= ST_RUN;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      taken_q       <= 1'b0;
      misalign_q    <= 1'b0;
      slot_viol_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      tgt_q         <= tgt_d;
      state_q       <= state_d;
      fetch_valid_q <= 1'b1;
      flush_q       <= flush_d;
      taken_q       <= taken_d;
      misalign_q    <= misalign_d;
      slot_viol_q   <= slot_viol_d;
    end
  end

  assign pc             = pc_q;
  assign fetch_valid    = fetch_valid_q;
  assign flush          = flush_q;
  assign taken          = taken_q;
  assign link_addr      = pc_decode + LINK_OFS;
  assign redirect_pend  = (state_q == ST_WAIT_SLOT);
  assign misalign_fault = misalign_q;
  assign slot_violation = slot_viol_q;

endmodule
